// File: rtl/ru_fault_scheduler_pkg.sv
// Shared types for the recompute-unit fault scheduler.
//   state_t : scheduler FSM states
//   asg_t   : one RU assignment {ru, row, col}, fields wide enough for any
//             supported array size
//   clog2w  : $clog2 that never returns less than 1, for port/counter widths
package ru_fault_scheduler_pkg;

  localparam int ASG_FW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [ASG_FW-1:0] ru;
    logic [ASG_FW-1:0] row;
    logic [ASG_FW-1:0] col;
  } asg_t;

  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ru_fault_scheduler_if.sv
// Assignment handshake between the scheduler (master) and the RU
// configuration sink (slave).
//   asg_valid : assignment offered
//   asg_ready : sink accepts
//   asg_ru    : RU index
//   asg_row   : faulty PE row
//   asg_col   : faulty PE column
interface ru_fault_scheduler_if #(
  parameter int RU_W  = 2,
  parameter int ROW_W = 2,
  parameter int COL_W = 2
) ();
  logic             asg_valid;
  logic             asg_ready;
  logic [RU_W-1:0]  asg_ru;
  logic [ROW_W-1:0] asg_row;
  logic [COL_W-1:0] asg_col;

  modport master (output asg_valid, asg_ru, asg_row, asg_col, input asg_ready);
  modport slave  (input asg_valid, asg_ru, asg_row, asg_col, output asg_ready);
endinterface

// File: rtl/ru_remaining_fault_detect.sv
// Combinational check: is any latched fault bit set above the current
// row-major index?
//   mat       : latched fault matrix, bit row*COLS+col
//   idx       : current scan index
//   any_above : some bit with index > idx is set
module ru_remaining_fault_detect #(
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     mat,
  input  logic [IDX_W-1:0] idx,
  output logic             any_above
);
  always_comb begin
    any_above = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((IDX_W'(i) > idx) && mat[i]) any_above = 1'b1;
    end
  end
endmodule

// File: rtl/ru_fault_scheduler.sv
// Scans a latched PE fault matrix in row-major order and hands each faulty
// PE to the next free recompute unit over a valid/ready handshake.
//   clk, rst (async, active low), start, fault_mat : control and test result
//   asg                                            : assignment handshake
//   ru_row_sel, ru_col_sel, ru_used                : per-RU configuration
//   busy, done, fault_count, overflow              : pass status
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | examining PE at idx_q
// ISSUE | offering current faulty PE to RU ru_cnt_q
// DONE  | one-cycle end-of-pass pulse
module ru_fault_scheduler
  import ru_fault_scheduler_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int NUM_RU = 3,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = clog2w(N),
  localparam int RU_W  = clog2w(NUM_RU),
  localparam int ROW_W = clog2w(ROWS),
  localparam int COL_W = clog2w(COLS),
  localparam int FC_W  = clog2w(N + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS-1:0][COLS-1:0]     fault_mat,
  ru_fault_scheduler_if.master          asg,
  output logic [NUM_RU-1:0][ROWS-1:0]   ru_row_sel,
  output logic [NUM_RU-1:0][COLS-1:0]   ru_col_sel,
  output logic [NUM_RU-1:0]             ru_used,
  output logic                          busy,
  output logic                          done,
  output logic [FC_W-1:0]               fault_count,
  output logic                          overflow
);
  state_t                      state_q, state_d;
  logic [N-1:0]                mat_q, mat_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic [RU_W-1:0]             ru_cnt_q, ru_cnt_d;
  logic [NUM_RU-1:0]           used_q, used_d;
  logic [NUM_RU-1:0][ROWS-1:0] row_sel_q, row_sel_d;
  logic [NUM_RU-1:0][COLS-1:0] col_sel_q, col_sel_d;
  logic [FC_W-1:0]             fc_q, fc_d;
  logic                        ovf_q, ovf_d;

  logic             any_above;
  logic             last_pe;
  logic             ru_last;
  logic [IDX_W-1:0] nxt_idx;
  logic [ROW_W-1:0] nxt_row;
  logic [COL_W-1:0] nxt_col;

  ru_remaining_fault_detect #(.N(N), .IDX_W(IDX_W)) u_remaining (
    .mat       (mat_q),
    .idx       (idx_q),
    .any_above (any_above)
  );

  assign last_pe = (idx_q == IDX_W'(N - 1));
  assign ru_last = (ru_cnt_q == RU_W'(NUM_RU - 1));

  // Row/column are tracked alongside the flat index to avoid a divider.
  always_comb begin
    nxt_idx = idx_q + IDX_W'(1);
    nxt_row = row_q;
    nxt_col = col_q + COL_W'(1);
    if (col_q == COL_W'(COLS - 1)) begin
      nxt_col = '0;
      nxt_row = row_q + ROW_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    mat_d     = mat_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    ru_cnt_d  = ru_cnt_q;
    used_d    = used_q;
    row_sel_d = row_sel_q;
    col_sel_d = col_sel_q;
    fc_d      = fc_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mat_d     = fault_mat;
          fc_d      = FC_W'($countones(fault_mat));
          idx_d     = '0;
          row_d     = '0;
          col_d     = '0;
          ru_cnt_d  = '0;
          used_d    = '0;
          row_sel_d = '0;
          col_sel_d = '0;
          ovf_d     = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (mat_q[idx_q]) begin
          state_d = ISSUE;
        end else if (last_pe) begin
          state_d = DONE;
        end else begin
          idx_d = nxt_idx;
          row_d = nxt_row;
          col_d = nxt_col;
        end
      end
      ISSUE: begin
        if (asg.asg_ready) begin
          used_d[ru_cnt_q]    = 1'b1;
          row_sel_d[ru_cnt_q] = ROWS'(1) << row_q;
          col_sel_d[ru_cnt_q] = COLS'(1) << col_q;
          if (last_pe || ru_last) begin
            // Counter/index stay put: nothing reads them until the next start.
            ovf_d   = ru_last && any_above;
            state_d = DONE;
          end else begin
            ru_cnt_d = ru_cnt_q + RU_W'(1);
            idx_d    = nxt_idx;
            row_d    = nxt_row;
            col_d    = nxt_col;
            state_d  = SCAN;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mat_q     <= '0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ru_cnt_q  <= '0;
      used_q    <= '0;
      row_sel_q <= '0;
      col_sel_q <= '0;
      fc_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mat_q     <= mat_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ru_cnt_q  <= ru_cnt_d;
      used_q    <= used_d;
      row_sel_q <= row_sel_d;
      col_sel_q <= col_sel_d;
      fc_q      <= fc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign asg.asg_valid = (state_q == ISSUE);
  assign asg.asg_ru    = ru_cnt_q;
  assign asg.asg_row   = row_q;
  assign asg.asg_col   = col_q;
  assign ru_row_sel    = row_sel_q;
  assign ru_col_sel    = col_sel_q;
  assign ru_used       = used_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign fault_count   = fc_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_ru_fault_scheduler.sv
module tb_ru_fault_scheduler;
  import ru_fault_scheduler_pkg::*;

  localparam int R  = 3;
  localparam int C  = 3;
  localparam int NR = 3;
  localparam int N  = R * C;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [R-1:0][C-1:0] fault_mat = '0;
  logic [NR-1:0][R-1:0] ru_row_sel;
  logic [NR-1:0][C-1:0] ru_col_sel;
  logic [NR-1:0]      ru_used;
  logic               busy, done, overflow;
  logic [3:0]         fault_count;

  int total = 0;
  int bad   = 0;

  ru_fault_scheduler_if #(.RU_W(2), .ROW_W(2), .COL_W(2)) asg_if ();

  always #5 clk = ~clk;

  ru_fault_scheduler #(.ROWS(R), .COLS(C), .NUM_RU(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fault_mat   (fault_mat),
    .asg         (asg_if.master),
    .ru_row_sel  (ru_row_sel),
    .ru_col_sel  (ru_col_sel),
    .ru_used     (ru_used),
    .busy        (busy),
    .done        (done),
    .fault_count (fault_count),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: faulty PEs in row-major order, first NR of them get RU0..RU(NR-1).
  task automatic model(input logic [8:0] mat, output asg_t q[$], output int fc,
                       output bit ovf, output int scanned);
    asg_t a;
    q = {};
    fc = $countones(mat);
    scanned = N;
    for (int i = 0; i < N; i++) begin
      if (mat[i] && q.size() < NR) begin
        a.ru  = 8'(q.size());
        a.row = 8'(i / C);
        a.col = 8'(i % C);
        q.push_back(a);
        if (q.size() == NR) scanned = i + 1;
      end
    end
    ovf = (fc > NR);
  endtask

  task automatic run_pass(input string nm, input logic [8:0] mat, input int st_lo,
                          input int st_hi, input bit mid_start);
    asg_t q[$];
    asg_t held;
    int fc, scanned, nexp, ncyc, stalls, stall_left;
    bit ovf, offering, finished;
    logic [8:0] rs, cs;
    logic [2:0] used;

    model(mat, q, fc, ovf, scanned);
    nexp = q.size();
    rs = '0; cs = '0; used = '0;
    for (int k = 0; k < nexp; k++) begin
      rs[k*3 +: 3] = 3'(1) << q[k].row;
      cs[k*3 +: 3] = 3'(1) << q[k].col;
      used[k] = 1'b1;
    end

    @(negedge clk);
    fault_mat = mat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncyc = 1;
    check({nm, "_fc_first"}, 32'(fault_count), 32'(fc));
    stalls = 0; offering = 0; finished = 0; stall_left = 0; held = '0;

    while (!finished && ncyc <= 200) begin
      if (mid_start && ncyc == 2) begin
        start = 1'b1;
        fault_mat = 9'($urandom_range(0, 511));
      end else begin
        start = 1'b0;
      end
      if (done) begin
        finished = 1;
        check({nm, "_latency"}, 32'(ncyc), 32'(scanned + nexp + stalls + 1));
        check({nm, "_missing"}, 32'(q.size()), 32'(0));
        check({nm, "_used"}, 32'(ru_used), 32'(used));
        check({nm, "_rowsel"}, 32'(ru_row_sel), 32'(rs));
        check({nm, "_colsel"}, 32'(ru_col_sel), 32'(cs));
        check({nm, "_ovf"}, 32'(overflow), 32'(ovf));
        check({nm, "_fc"}, 32'(fault_count), 32'(fc));
        check({nm, "_busy_done"}, 32'(busy), 32'(1));
      end else begin
        check({nm, "_busy"}, 32'(busy), 32'(1));
        if (asg_if.asg_valid) begin
          if (!offering) begin
            if (q.size() == 0) begin
              check({nm, "_extra_asg"}, 32'(asg_if.asg_valid), 32'(0));
            end else begin
              held = q[0];
              check({nm, "_asg"}, {26'd0, asg_if.asg_ru, asg_if.asg_row, asg_if.asg_col},
                    {26'd0, held.ru[1:0], held.row[1:0], held.col[1:0]});
              offering = 1;
              stall_left = $urandom_range(st_hi, st_lo);
            end
          end else begin
            check({nm, "_hold"}, {26'd0, asg_if.asg_ru, asg_if.asg_row, asg_if.asg_col},
                  {26'd0, held.ru[1:0], held.row[1:0], held.col[1:0]});
          end
          if (offering && stall_left > 0) begin
            asg_if.asg_ready = 1'b0;
            stall_left--;
            stalls++;
          end else if (offering) begin
            asg_if.asg_ready = 1'b1;
            offering = 0;
            void'(q.pop_front());
          end
        end else begin
          asg_if.asg_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        ncyc++;
      end
    end
    start = 1'b0;
    if (!finished) check({nm, "_timeout"}, 32'(done), 32'(1));

    @(negedge clk);
    check({nm, "_done_pulse"}, {30'd0, done, busy}, 32'(0));
    check({nm, "_held"}, {18'd0, ru_used, overflow, fault_count, asg_if.asg_valid, 4'd0},
          {18'd0, used, ovf, 4'(fc), 1'b0, 4'd0});
  endtask

  initial begin
    int w;
    asg_if.asg_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(|{asg_if.asg_valid, asg_if.asg_ru, asg_if.asg_row, asg_if.asg_col,
          ru_row_sel, ru_col_sel, ru_used, busy, done, fault_count, overflow}), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));

    run_pass("offdiag", 9'b011101110, 0, 0, 1'b0);
    run_pass("zero", 9'b000000000, 0, 0, 1'b0);
    run_pass("single22", 9'b100000000, 4, 4, 1'b0);
    run_pass("diag", 9'b100010001, 0, 2, 1'b0);
    run_pass("busy_start", 9'b011101110, 0, 1, 1'b1);

    // Reset while an assignment is pending.
    @(negedge clk);
    fault_mat = 9'b011101110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    asg_if.asg_ready = 1'b0;
    w = 0;
    while (!asg_if.asg_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rst_reach_issue", 32'(asg_if.asg_valid), 32'(1));
    #2 rst = 1'b0;
    #1;
    check("rst_async_clear", 32'(|{asg_if.asg_valid, asg_if.asg_ru, asg_if.asg_row, asg_if.asg_col,
          ru_row_sel, ru_col_sel, ru_used, busy, done, fault_count, overflow}), 32'(0));
    asg_if.asg_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_asg", {30'd0, asg_if.asg_valid, busy}, 32'(0));
    run_pass("post_rst", 9'b011101110, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_pass($sformatf("rand%0d", i), 9'($urandom_range(0, 511)), 0, 2, (i % 2) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
